// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit
// Converts byte-addressed RISC-V loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW)
// arriving over a valid/ready handshake into single-word accesses on a
// word-addressed data memory. Sub-word loads are lane-extracted and
// sign/zero-extended; sub-word stores are read-modify-write. Illegal,
// misaligned or out-of-range requests answer with resp_err and never
// strobe the memory.
//
// Ports:
//   clk, rst_n          clock (posedge) and synchronous active-low reset
//   req_valid/req_ready request handshake; accept on valid && ready
//   req_we              1 = store, 0 = load
//   req_funct3          RISC-V width/sign code
//   req_addr            byte address
//   req_wdata           store data (low byte/half for SB/SH)
//   resp_valid          one-cycle registered completion pulse
//   resp_rdata          registered load result (0 for stores and errors)
//   resp_err            registered error flag, valid with resp_valid
//   mem_addr            word index of the captured address
//   mem_write_data      word written on mem_memwrite
//   mem_memwrite        write strobe
//   mem_memread         read strobe
//   mem_read_data       read word, valid the cycle after the read edge
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_EXT, S_MERGE, S_WR, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_f3_bad;
  logic        w_misalign;
  logic        w_range;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_merged;
  logic        w_resp;
  logic        w_resp_err;
  logic [31:0] w_resp_rdata;

  assign req_ready      = (r_state == S_IDLE) && rst_n;
  assign w_accept       = req_valid && req_ready;
  assign mem_addr       = {2'b00, r_addr[31:2]};
  // r_wdata holds the raw store word for SW and the merged word for SB/SH
  assign mem_write_data = r_wdata;
  assign resp_valid     = r_resp_valid;
  assign resp_err       = r_resp_err;
  assign resp_rdata     = r_resp_rdata;

  // Request legality, evaluated on the live request at accept time
  always_comb begin
    if (req_we)
      w_f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      w_f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_range    = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    w_err      = w_f3_bad || w_misalign || w_range;
  end

  // Load lane extraction and store lane merge on the returned word
  always_comb begin
    w_byte = mem_read_data[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = mem_read_data;
    endcase
    w_merged = mem_read_data;
    if (r_funct3[1:0] == 2'b00)
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_comb begin
    w_next       = r_state;
    w_resp       = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_rdata = '0;
    mem_memread  = (r_state == S_RD) && rst_n;
    mem_memwrite = (r_state == S_WR) && rst_n;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)                                w_next = S_ERR;
          else if (req_we && req_funct3 == 3'b010) w_next = S_WR;
          else                                      w_next = S_RD;
        end
      end
      S_RD:    w_next = r_we ? S_MERGE : S_EXT;
      S_EXT: begin
        w_next       = S_IDLE;
        w_resp       = 1'b1;
        w_resp_rdata = w_ext;
      end
      S_MERGE: w_next = S_WR;
      S_WR: begin
        w_next = S_IDLE;
        w_resp = 1'b1;
      end
      S_ERR: begin
        w_next     = S_IDLE;
        w_resp     = 1'b1;
        w_resp_err = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_we         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_resp;
      if (w_resp) begin
        r_resp_err   <= w_resp_err;
        r_resp_rdata <= w_resp_rdata;
      end
      if (w_accept) begin
        r_addr   <= req_addr;
        r_funct3 <= req_funct3;
        r_we     <= req_we;
        r_wdata  <= req_wdata;
      end else if (r_state == S_MERGE) begin
        r_wdata <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Self-checking bench for load_store_unit: directed vector table, hand-built
// reset and back-to-back sequences, then random requests against a
// word-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data = '0;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory environment
  logic [31:0] env_mem  [256];
  logic [31:0] seed_mem [256];
  logic [31:0] ref_mem  [256];
  logic        do_init = 1'b0;
  logic [31:0] last_wr_addr = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;

  always @(posedge clk) begin
    if (do_init)
      for (int i = 0; i < 256; i++) env_mem[i] <= seed_mem[i];
    if (mem_memwrite) begin
      env_mem[mem_addr[7:0]] <= mem_write_data;
      last_wr_addr <= mem_addr;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_memread) begin
      mem_read_data <= env_mem[mem_addr[7:0]];
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_memread && mem_memwrite) both_cnt <= both_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: byte-granular view of the word array
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd,
                       output int lat, output int nrd, output int nwr);
    int unsigned au, idx, sz, sh;
    logic [31:0] mask, word;
    bit legal;
    au    = a;
    idx   = au / 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e     = !legal || (au % sz != 0) || (idx >= 256);
    rd = '0; lat = 1; nrd = 0; nwr = 0;
    if (!e) begin
      word = ref_mem[idx];
      sh   = (au % 4) * 8;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      if (!we) begin
        rd = (word >> sh) & mask;
        if (!f3[2] && sz < 4 && rd[8*sz-1]) rd = rd | ~mask;
        lat = 2; nrd = 1;
      end else begin
        ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
        lat = (sz == 4) ? 1 : 3;
        nrd = (sz == 4) ? 0 : 1;
        nwr = 1;
      end
    end
  endtask

  // Issue one request, wait for its response; lat = edges from accept to response
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic e, output logic [31:0] rd,
                        output int lat, output int nrd, output int nwr);
    int rd0, wr0, k;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    lat = -1; e = 1'b0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = i; e = resp_err; rd = resp_rdata;
        break;
      end
    end
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e, me;
    logic [31:0] rd, mrd, exp_lw, wd2;
    int          lat, nrd, nwr, mlat, mnrd, mnwr, wr0, seen;

    tbl[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1, 0, 1};
    tbl[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0};
    tbl[2]  = '{1'b0, 3'b000, 32'h13,  32'h0,        1'b0, 32'hFFFFFFDE, 2, 1, 0};
    tbl[3]  = '{1'b0, 3'b100, 32'h13,  32'h0,        1'b0, 32'h000000DE, 2, 1, 0};
    tbl[4]  = '{1'b0, 3'b001, 32'h12,  32'h0,        1'b0, 32'hFFFFDEAD, 2, 1, 0};
    tbl[5]  = '{1'b0, 3'b101, 32'h10,  32'h0,        1'b0, 32'h0000BEEF, 2, 1, 0};
    tbl[6]  = '{1'b1, 3'b000, 32'h11,  32'h12345678, 1'b0, 32'h0,        3, 1, 1};
    tbl[7]  = '{1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEAD78EF, 2, 1, 0};
    tbl[8]  = '{1'b1, 3'b001, 32'h12,  32'hAAAA5555, 1'b0, 32'h0,        3, 1, 1};
    tbl[9]  = '{1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h555578EF, 2, 1, 0};
    tbl[10] = '{1'b0, 3'b010, 32'h12,  32'h0,        1'b1, 32'h0,        1, 0, 0};
    tbl[11] = '{1'b1, 3'b001, 32'h11,  32'hFFFFFFFF, 1'b1, 32'h0,        1, 0, 0};
    tbl[12] = '{1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'h0,        1, 0, 0};
    tbl[13] = '{1'b1, 3'b000, 32'h400, 32'h000000AA, 1'b1, 32'h0,        1, 0, 0};
    tbl[14] = '{1'b1, 3'b100, 32'h10,  32'h11111111, 1'b1, 32'h0,        1, 0, 0};
    tbl[15] = '{1'b1, 3'b010, 32'h3FC, 32'h01234567, 1'b0, 32'h0,        1, 0, 1};
    tbl[16] = '{1'b0, 3'b010, 32'h3FC, 32'h0,        1'b0, 32'h01234567, 2, 1, 0};
    tbl[17] = '{1'b0, 3'b001, 32'h3FE, 32'h0,        1'b0, 32'h00000123, 2, 1, 0};

    for (int i = 0; i < 256; i++) begin
      seed_mem[i] = $urandom;
      ref_mem[i]  = seed_mem[i];
    end

    // Reset state
    do_init = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_init = 1'b0;
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_err",   32'(resp_err),   32'd0);
    chk("rst resp_rdata", resp_rdata,      32'd0);
    chk("rst mem_addr",   mem_addr,        32'd0);
    chk("rst memread",    32'(mem_memread),  32'd0);
    chk("rst memwrite",   32'(mem_memwrite), 32'd0);
    chk("rst req_ready",  32'(req_ready),    32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle req_ready", 32'(req_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, me, mrd, mlat, mnrd, mnwr);
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, e, rd, lat, nrd, nwr);
      chk($sformatf("vec%0d err", i),   32'(e),   32'(tbl[i].err));
      chk($sformatf("vec%0d rdata", i), rd,       tbl[i].rdata);
      chk($sformatf("vec%0d lat", i),   32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d nread", i), 32'(nrd), 32'(tbl[i].nrd));
      chk($sformatf("vec%0d nwrite", i),32'(nwr), 32'(tbl[i].nwr));
      if (i == 0) chk("sw mem_addr", last_wr_addr, 32'd4);
    end

    // Reset while an SB sits in MERGE
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h000000A5;
    req_valid = 1'b1;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wr0 = wr_cnt;
    seen = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst memwrite", 32'(mem_memwrite), 32'd0);
    chk("mrst memread",  32'(mem_memread),  32'd0);
    chk("mrst req_ready",32'(req_ready),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst resp_valid", 32'(resp_valid), 32'd0);
    chk("mrst mem_addr",   mem_addr,        32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("mrst no resp",  32'(seen), 32'd0);
    chk("mrst no write", 32'(wr_cnt - wr0), 32'd0);
    model(1'b0, 3'b010, 32'h10, 32'h0, me, mrd, mlat, mnrd, mnwr);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, e, rd, lat, nrd, nwr);
    chk("mrst word4",   rd,       mrd);
    chk("mrst lw lat",  32'(lat), 32'(mlat));
    chk("mrst lw err",  32'(e),   32'(me));

    // Back-to-back: LW 0x10 then SW 0x14 with req_valid held
    wd2 = $urandom;
    model(1'b0, 3'b010, 32'h10, 32'h0, me, exp_lw, mlat, mnrd, mnwr);
    model(1'b1, 3'b010, 32'h14, wd2,   me, mrd,    mlat, mnrd, mnwr);
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h14; req_wdata = wd2;
    seen = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
      if (i == 1) chk("b2b no early resp", 32'(resp_valid), 32'd0);
      if (i == 2) begin
        chk("b2b lw valid", 32'(resp_valid), 32'd1);
        chk("b2b lw data",  resp_rdata,      exp_lw);
        chk("b2b lw ready", 32'(req_ready),  32'd1);
      end
      if (i == 3) begin
        chk("b2b sw accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
      end
      if (i == 4) begin
        chk("b2b sw valid", 32'(resp_valid), 32'd1);
        chk("b2b sw err",   32'(resp_err),   32'd0);
      end
    end
    chk("b2b resp count", 32'(seen), 32'd2);
    model(1'b0, 3'b010, 32'h14, 32'h0, me, mrd, mlat, mnrd, mnwr);
    do_req(1'b0, 3'b010, 32'h14, 32'h0, e, rd, lat, nrd, nwr);
    chk("b2b readback", rd, mrd);

    // Random requests against the reference model
    for (int i = 0; i < 300; i++) begin
      bit          rwe;
      logic [2:0]  rf3;
      logic [31:0] ra, rwd;
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra  = 32'($urandom_range(0, 1040));
      rwd = $urandom;
      model(rwe, rf3, ra, rwd, me, mrd, mlat, mnrd, mnwr);
      do_req(rwe, rf3, ra, rwd, e, rd, lat, nrd, nwr);
      chk($sformatf("rnd%0d err", i),    32'(e),   32'(me));
      chk($sformatf("rnd%0d rdata", i),  rd,       mrd);
      chk($sformatf("rnd%0d lat", i),    32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d nread", i),  32'(nrd), 32'(mnrd));
      chk($sformatf("rnd%0d nwrite", i), 32'(nwr), 32'(mnwr));
    end

    chk("read/write overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store front end between the execute stage and the word-addressed data memory. Takes byte-addressed RISC-V loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) over a valid/ready handshake and converts them into word accesses on the memory's addr/write_data/memwrite/memread/read_data port. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write. Misaligned, illegal or out-of-range accesses return an error without touching memory.

## Interface
- MEM_WORDS, 256, number of 32-bit words in the data memory; legal word index range is 0..MEM_WORDS-1

- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE with rst_n high; a request is accepted on an edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse, registered
- resp_rdata  out  32  load result, registered; 0 for stores and errors
- resp_err  out  1  registered; valid with resp_valid
- mem_addr  out  32  word index = captured byte address >> 2
- mem_write_data  out  32  word to write
- mem_memwrite  out  1  write strobe, forced 0 while rst_n low
- mem_memread  out  1  read strobe
- mem_read_data  in  32  memory read word; valid the cycle after the memread edge

## Operation
- On accept, capture address, funct3, we and wdata into internal registers. mem_addr is driven from the captured address.
- FSM states: IDLE, RD, EXT, MERGE, WR, ERR.
- Error check happens at accept; an error sends the FSM to ERR. Any of these is an error:
  - load funct3 in {011, 110, 111}
  - store funct3 not in {000, 001, 010}
  - H/HU with addr[0] = 1
  - W with addr[1:0] != 0
  - word index >= MEM_WORDS
- Load path: IDLE -> RD -> EXT -> IDLE.
  - RD asserts mem_memread.
  - EXT extracts the byte or half from mem_read_data and registers resp_rdata with resp_valid = 1.
- Byte lane select: byte k = addr[1:0] -> bits [8k+7:8k]. Half h = addr[1] -> bits [16h+15:16h].
- Extension: B and H sign-extend; BU and HU zero-extend.
- SW path: IDLE -> WR -> IDLE. WR asserts mem_memwrite with mem_write_data = wdata.
- SB/SH path: IDLE -> RD -> MERGE -> WR -> IDLE.
  - MERGE registers mem_read_data with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - WR writes the merged word.
- ERR: one cycle, no memory strobes; returns to IDLE with resp_valid = 1, resp_err = 1, resp_rdata = 0.
- mem_memread and mem_memwrite are never asserted in the same cycle and each is high for exactly one cycle per access.
- Reset (rst_n low at an edge):
  - state -> IDLE
  - resp_valid, resp_err, resp_rdata, captured registers and mem_addr -> 0
  - mem_memread, mem_memwrite = 0 during the reset cycle
- An in-flight operation is abandoned with no write and no response. This includes reset in WR.

## Timing
- Accept edge = N.
- Load: memread high in cycle N..N+1; resp_valid high for the cycle after edge N+2.
- SW: memwrite high in cycle N..N+1; resp_valid after edge N+1.
- SB/SH: memread in cycle N..N+1, MERGE in cycle N+1..N+2, memwrite in cycle N+2..N+3; resp_valid after edge N+3.
- Error: resp_valid after edge N+1.
- req_ready is high in the same cycle resp_valid is high, so back-to-back requests have no bubble beyond the listed latency.
- req_valid while req_ready = 0 is ignored. The requester holds the request until accepted.

## Test plan
- SW 0x10, data 0xDEADBEEF:
  - mem_addr = 4, one memwrite cycle, resp_valid at N+1, resp_err = 0.
  - Follow-up LW 0x10 returns 0xDEADBEEF at N+2.
- Loads from word 4 (0xDEADBEEF):
  - LB 0x13 -> 0xFFFFFFDE
  - LBU 0x13 -> 0x000000DE
  - LH 0x12 -> 0xFFFFDEAD
  - LHU 0x10 -> 0x0000BEEF
- Sub-word stores:
  - SB 0x11, data 0x12345678 -> word 4 = 0xDEAD78EF, resp at N+3.
  - Then SH 0x12, data 0xAAAA5555 -> word 4 = 0x555578EF.
  - Exactly one memread and one memwrite per store.
- Error cases, each giving resp_err = 1, resp_rdata = 0, resp at N+1, no memread or memwrite:
  - LW 0x12
  - SH 0x11
  - load funct3 011
  - SB 0x400 (word 256 with MEM_WORDS = 256)
- Reset mid-operation: rst_n low for one edge while in MERGE of SB 0x10 -> state IDLE, no memwrite, no resp_valid, word 4 unchanged; the next request completes normally.
- Back-to-back: req_valid held high with LW 0x10 then SW 0x14 -> second accept on the edge ending the resp_valid cycle of the first; no lost or duplicated responses.
